seq_divider: RTL and testbench

- Multi-cycle integer divider for the miniSRC ALU; the subtractive counterpart to the datapath adder.
- Implements non-restoring division, one quotient bit per clock.
- Results go to the LO register (quotient) and the HI register (remainder) via the ALU result mux.
- Uses a start/done handshake so the control unit can stall while busy is high.

---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 166 ++++++++++++++++
 tb/tb_seq_divider.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle for the sequential divider.
// The control unit uses the master side; seq_divider uses the slave side.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Non-restoring sequential divider, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands (truncating division).
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] dividend_mag, divisor_mag;
    logic [WIDTH:0]   d_ext, p_shift, p_step, p_fix;
    logic [WIDTH-1:0] rem_fix, quot_final, rem_final;

`ifdef SIGNED_DIV_EN
    logic negq_q, negq_d;
    logic negr_q, negr_d;

    assign dividend_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
    assign divisor_mag  = bus.divisor[WIDTH-1]  ? (~bus.divisor + WIDTH'(1))  : bus.divisor;
    assign quot_final   = negq_q ? (~a_q + WIDTH'(1))     : a_q;
    assign rem_final    = negr_q ? (~rem_fix + WIDTH'(1)) : rem_fix;
`else
    assign dividend_mag = bus.dividend;
    assign divisor_mag  = bus.divisor;
    assign quot_final   = a_q;
    assign rem_final    = rem_fix;
`endif

    // Sums are taken modulo 2^(WIDTH+1); the in-range result makes the dropped P MSB harmless.
    assign d_ext   = {1'b0, d_q};
    assign p_shift = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
    assign p_step  = p_q[WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);
    assign p_fix   = p_q[WIDTH] ? (p_q + d_ext) : p_q;
    assign rem_fix = p_fix[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        a_d     = a_q;
        d_d     = d_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef SIGNED_DIV_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    d_d    = divisor_mag;
                    p_d    = '0;
                    busy_d = 1'b1;
`ifdef SIGNED_DIV_EN
                    negq_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    negr_d = bus.dividend[WIDTH-1];
`endif
                    // A zero divisor skips the iterations; A carries the raw dividend out as the remainder.
                    if (bus.divisor == '0) begin
                        zero_d  = 1'b1;
                        a_d     = bus.dividend;
                        cnt_d   = '0;
                        state_d = FIX;
                    end else begin
                        zero_d  = 1'b0;
                        a_d     = dividend_mag;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                p_d   = p_step;
                a_d   = {a_q[WIDTH-2:0], ~p_step[WIDTH]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                p_d     = p_fix;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dz_d    = zero_q;
                state_d = IDLE;
                if (zero_q) begin
                    quot_d = '1;
                    rem_d  = a_q;
                end else begin
                    quot_d = quot_final;
                    rem_d  = rem_final;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            a_q     <= '0;
            d_q     <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            a_q     <= a_d;
            d_q     <= d_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

`ifdef SIGNED_DIV_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else begin
            negq_q <= negq_d;
            negr_q <= negr_d;
        end
    end
`endif

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: table of divides plus reset and handshake sequences.
// Signed expectations are selected with SIGNED_DIV_EN, matching the RTL build.
module tb_seq_divider;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam int NORMAL_LAT = WIDTH + 1;
    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_divider #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string            name;
        logic [WIDTH-1:0] dividend;
        logic [WIDTH-1:0] divisor;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
        int               lat;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int failures = 0;
    int edgeCount = 0;
    int startEdge = 0;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Presents operands for one cycle; leaves us at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input bit holdStart);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1 startEdge = edgeCount;
        @(negedge clk);
        if (!holdStart) bus.start = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = b ^ 32'h5A5A_5A5A;
    endtask

    task automatic waitDone(input string name, output int latency);
        int guard;
        guard = 0;
        latency = -1;
        while (bus.done !== 1'b1 && guard < TIMEOUT) begin
            @(negedge clk);
            guard++;
        end
        if (bus.done === 1'b1) begin
            latency = edgeCount - startEdge;
        end else begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout actual=no_done required=done", name);
        end
    endtask

    task automatic checkResult(input string name, input logic [WIDTH-1:0] q,
                               input logic [WIDTH-1:0] r, input logic dz, input int lat,
                               input int latency);
        checkOutput({name, "_lat"}, WIDTH'(latency), WIDTH'(lat));
        checkOutput({name, "_q"}, bus.quotient, q);
        checkOutput({name, "_r"}, bus.remainder, r);
        checkOutput({name, "_dz"}, WIDTH'(bus.div_by_zero), WIDTH'(dz));
        checkOutput({name, "_busy"}, WIDTH'(bus.busy), '0);
    endtask

    initial begin
        int latency;
        int seen;

        vecs.push_back('{"u100_7",   32'd100,        32'd7,          32'd14,         32'd2,   1'b0, NORMAL_LAT});
        vecs.push_back('{"max_1",    32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,   1'b0, NORMAL_LAT});
        vecs.push_back('{"small",    32'd5,          32'd9,          32'd0,          32'd5,   1'b0, NORMAL_LAT});
        vecs.push_back('{"zero_num", 32'd0,          32'd3,          32'd0,          32'd0,   1'b0, NORMAL_LAT});
        vecs.push_back('{"max_max",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,   1'b0, NORMAL_LAT});
        vecs.push_back('{"k1000_10", 32'd1000,       32'd10,         32'd100,        32'd0,   1'b0, NORMAL_LAT});
`ifdef SIGNED_DIV_EN
        vecs.push_back('{"s_m7_2",   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0, NORMAL_LAT});
        vecs.push_back('{"s_7_m2",   32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,   1'b0, NORMAL_LAT});
        vecs.push_back('{"s_minneg", 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,   1'b0, NORMAL_LAT});
`else
        vecs.push_back('{"u_big_2",  32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,   1'b0, NORMAL_LAT});
        vecs.push_back('{"u_7_big",  32'd7,          32'hFFFF_FFFE,  32'd0,          32'd7,   1'b0, NORMAL_LAT});
        vecs.push_back('{"u_msb",    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000, 1'b0, NORMAL_LAT});
`endif
        vecs.push_back('{"dz_1234",  32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234, 1'b1, 1});
        vecs.push_back('{"dz_neg",   32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9, 1'b1, 1});
        vecs.push_back('{"hex",      32'h1234_5678,  32'h0000_0100,  32'h0012_3456,  32'h78,  1'b0, NORMAL_LAT});

        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", WIDTH'(bus.busy), '0);
        checkOutput("rst_done", WIDTH'(bus.done), '0);
        checkOutput("rst_q", bus.quotient, '0);
        checkOutput("rst_r", bus.remainder, '0);
        checkOutput("rst_dz", WIDTH'(bus.div_by_zero), '0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].dividend, vecs[i].divisor, 1'b0);
            waitDone(vecs[i].name, latency);
            checkResult(vecs[i].name, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat, latency);
            @(negedge clk);
            checkOutput({vecs[i].name, "_pulse"}, WIDTH'(bus.done), '0);
        end

        // Reset mid-ITER must clear results and suppress the pending done.
        applyStimulus(32'd100, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", WIDTH'(bus.busy), '0);
        checkOutput("midrst_q", bus.quotient, '0);
        checkOutput("midrst_r", bus.remainder, '0);
        rst = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        checkOutput("midrst_nodone", WIDTH'(seen), '0);

        // A start pulse while busy is ignored.
        applyStimulus(32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone("ignore", latency);
        checkResult("ignore", 32'd14, 32'd2, 1'b0, NORMAL_LAT, latency);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        checkOutput("ignore_nodone", WIDTH'(seen), '0);

        // start held high re-triggers in the done cycle.
        applyStimulus(32'd100, 32'd7, 1'b1);
        waitDone("b2b_first", latency);
        checkResult("b2b_first", 32'd14, 32'd2, 1'b0, NORMAL_LAT, latency);
        bus.dividend = 32'd1000;
        bus.divisor = 32'd10;
        @(posedge clk);
        #1 startEdge = edgeCount;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("b2b_busy", WIDTH'(bus.busy), WIDTH'(1));
        waitDone("b2b_second", latency);
        checkResult("b2b_second", 32'd100, 32'd0, 1'b0, NORMAL_LAT, latency);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
